// File: rtl/apb_splitter_pkg.sv
// -----------------------------------------------------------------------------
// apb_splitter_pkg
//   Shared types and constants for the APB one-to-many splitter:
//   - ADDR_W / DATA_W : APB address and data widths (32)
//   - IDX_W           : width of a decoded slave index (enough for 16 slaves)
//   - state_e         : transfer FSM states
//   - dec_res_t       : address-decode result (mapped flag + slave index)
// -----------------------------------------------------------------------------
package apb_splitter_pkg;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MAX_SLAVES = 16;
  localparam int IDX_W      = $clog2(MAX_SLAVES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef struct packed {
    logic             mapped;
    logic [IDX_W-1:0] idx;
  } dec_res_t;

endpackage

// File: rtl/apb_splitter_decode.sv
// -----------------------------------------------------------------------------
// apb_splitter_decode
//   Purely combinational address decoder. The field
//   paddr[SEL_LSB +: SEL_W] minus SEL_BASE selects a slave; the address is
//   mapped only when the field is at or above SEL_BASE and the resulting
//   index is below NUM_SLAVES.
//   Ports:
//     paddr : in  ADDR_W   upstream address
//     dec   : out dec_res_t  {mapped, idx}
// -----------------------------------------------------------------------------
module apb_splitter_decode
  import apb_splitter_pkg::*;
#(
  parameter int NUM_SLAVES = 2,
  parameter int SEL_LSB    = 28,
  parameter int SEL_W      = 4,
  parameter int SEL_BASE   = 4
) (
  input  logic [ADDR_W-1:0] paddr,
  output dec_res_t          dec
);

  logic [SEL_W-1:0] field;
  logic [31:0]      field_ext;
  logic [31:0]      offset;
  logic             unused_paddr;

  // Only the decode field matters; the reduction keeps the rest of the bus
  // visibly consumed.
  assign unused_paddr = ^paddr;

  always_comb begin
    field     = paddr[SEL_LSB +: SEL_W];
    field_ext = 32'(field);
    // Wrap-around below SEL_BASE is caught by the explicit >= test, so the
    // unsigned subtraction result is only trusted when that test passes.
    offset     = field_ext - 32'(SEL_BASE);
    dec.mapped = (field_ext >= 32'(SEL_BASE)) && (offset < 32'(NUM_SLAVES));
    dec.idx    = offset[IDX_W-1:0];
  end

endmodule

// File: rtl/apb_splitter.sv
// -----------------------------------------------------------------------------
// apb_splitter
//   Routes one upstream APB transfer at a time to one of NUM_SLAVES
//   downstream APB slaves selected by an address field. Unmapped addresses
//   and slaves that stall for TIMEOUT_CYCLES access cycles are answered
//   locally with an error. Every output is a flop.
//   Ports:
//     pclk, preset              : clock, synchronous active-high reset
//     in_psel/penable/pwrite    : upstream control          (in)
//     in_paddr, in_pwdata       : upstream address / data   (in, 32)
//     in_prdata, in_pready,
//     in_pslverr                : upstream response         (out)
//     out_psel                  : one-hot slave select      (out, NUM_SLAVES)
//     out_penable, out_pwrite,
//     out_paddr, out_pwdata     : shared downstream bus     (out)
//     out_prdata                : slave i at [32i+31:32i]   (in)
//     out_pready, out_pslverr   : per-slave response        (in, NUM_SLAVES)
//     stat_timeout, stat_decerr : one-cycle event pulses    (out)
// -----------------------------------------------------------------------------
module apb_splitter
  import apb_splitter_pkg::*;
#(
  parameter int NUM_SLAVES     = 2,
  parameter int SEL_LSB        = 28,
  parameter int SEL_W          = 4,
  parameter int SEL_BASE       = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                         pclk,
  input  logic                         preset,
  input  logic                         in_psel,
  input  logic                         in_penable,
  input  logic                         in_pwrite,
  input  logic [ADDR_W-1:0]            in_paddr,
  input  logic [DATA_W-1:0]            in_pwdata,
  output logic [DATA_W-1:0]            in_prdata,
  output logic                         in_pready,
  output logic                         in_pslverr,
  output logic [NUM_SLAVES-1:0]        out_psel,
  output logic                         out_penable,
  output logic                         out_pwrite,
  output logic [ADDR_W-1:0]            out_paddr,
  output logic [DATA_W-1:0]            out_pwdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] out_prdata,
  input  logic [NUM_SLAVES-1:0]        out_pready,
  input  logic [NUM_SLAVES-1:0]        out_pslverr,
  output logic                         stat_timeout,
  output logic                         stat_decerr
);

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_SLAVES-1:0]   out_psel_q, out_psel_d;
  logic                    out_penable_q, out_penable_d;
  logic                    out_pwrite_q, out_pwrite_d;
  logic [ADDR_W-1:0]       out_paddr_q, out_paddr_d;
  logic [DATA_W-1:0]       out_pwdata_q, out_pwdata_d;
  logic [DATA_W-1:0]       in_prdata_q, in_prdata_d;
  logic                    in_pready_q, in_pready_d;
  logic                    in_pslverr_q, in_pslverr_d;
  logic                    stat_timeout_q, stat_timeout_d;
  logic                    stat_decerr_q, stat_decerr_d;

  dec_res_t                in_dec;
  logic [NUM_SLAVES-1:0]   dec_onehot;
  logic                    sel_ready;
  logic                    sel_err;
  logic [DATA_W-1:0]       sel_rdata;

  apb_splitter_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_LSB    (SEL_LSB),
    .SEL_W      (SEL_W),
    .SEL_BASE   (SEL_BASE)
  ) u_decode (
    .paddr (in_paddr),
    .dec   (in_dec)
  );

  always_comb begin
    for (int i = 0; i < NUM_SLAVES; i++) begin
      dec_onehot[i] = (in_dec.idx == IDX_W'(i));
    end
  end

  // The registered one-hot select doubles as the captured slave index, so
  // the response mux keys directly off it.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (out_psel_q[i]) begin
        sel_ready = out_pready[i];
        sel_err   = out_pslverr[i];
        sel_rdata = out_prdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d        = state_q;
    cnt_d          = cnt_q;
    out_psel_d     = out_psel_q;
    out_penable_d  = out_penable_q;
    out_pwrite_d   = out_pwrite_q;
    out_paddr_d    = out_paddr_q;
    out_pwdata_d   = out_pwdata_q;
    in_prdata_d    = in_prdata_q;
    in_pslverr_d   = in_pslverr_q;
    in_pready_d    = 1'b0;
    stat_timeout_d = 1'b0;
    stat_decerr_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (in_psel && !in_penable) begin
          out_paddr_d  = in_paddr;
          out_pwrite_d = in_pwrite;
          out_pwdata_d = in_pwdata;
          if (in_dec.mapped) begin
            state_d    = ST_SETUP;
            out_psel_d = dec_onehot;
          end else begin
            state_d       = ST_RESP;
            in_pready_d   = 1'b1;
            in_pslverr_d  = 1'b1;
            in_prdata_d   = '0;
            stat_decerr_d = 1'b1;
          end
        end
      end

      ST_SETUP: begin
        state_d       = ST_ACCESS;
        out_penable_d = 1'b1;
        cnt_d         = '0;
      end

      ST_ACCESS: begin
        // pready is tested first so a slave answering on the limit cycle
        // still completes normally.
        if (sel_ready) begin
          state_d       = ST_RESP;
          out_psel_d    = '0;
          out_penable_d = 1'b0;
          in_pready_d   = 1'b1;
          in_prdata_d   = sel_rdata;
          in_pslverr_d  = sel_err;
        end else if (TO_EN && (cnt_q == CNT_LIMIT)) begin
          state_d        = ST_RESP;
          out_psel_d     = '0;
          out_penable_d  = 1'b0;
          in_pready_d    = 1'b1;
          in_prdata_d    = '0;
          in_pslverr_d   = 1'b1;
          stat_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      out_psel_q     <= '0;
      out_penable_q  <= 1'b0;
      out_pwrite_q   <= 1'b0;
      out_paddr_q    <= '0;
      out_pwdata_q   <= '0;
      in_prdata_q    <= '0;
      in_pready_q    <= 1'b0;
      in_pslverr_q   <= 1'b0;
      stat_timeout_q <= 1'b0;
      stat_decerr_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      out_psel_q     <= out_psel_d;
      out_penable_q  <= out_penable_d;
      out_pwrite_q   <= out_pwrite_d;
      out_paddr_q    <= out_paddr_d;
      out_pwdata_q   <= out_pwdata_d;
      in_prdata_q    <= in_prdata_d;
      in_pready_q    <= in_pready_d;
      in_pslverr_q   <= in_pslverr_d;
      stat_timeout_q <= stat_timeout_d;
      stat_decerr_q  <= stat_decerr_d;
    end
  end

  assign out_psel     = out_psel_q;
  assign out_penable  = out_penable_q;
  assign out_pwrite   = out_pwrite_q;
  assign out_paddr    = out_paddr_q;
  assign out_pwdata   = out_pwdata_q;
  assign in_prdata    = in_prdata_q;
  assign in_pready    = in_pready_q;
  assign in_pslverr   = in_pslverr_q;
  assign stat_timeout = stat_timeout_q;
  assign stat_decerr  = stat_decerr_q;

endmodule

// File: doc/apb_splitter.md
APB_SPLITTER -- requirements
Module: apb_splitter

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 2, number of downstream APB ports (legal range 2..16).
REQ-002 SHALL have parameter SEL_LSB, default 28, lowest paddr bit of the decode field.
REQ-003 SHALL have parameter SEL_W, default 4, width of the decode field.
REQ-004 SHALL have parameter SEL_BASE, default 4, decode-field value mapped to slave 0.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 256; 0 disables the timeout.
REQ-006 SHALL have ports: pclk in 1, the single clock; preset in 1, synchronous active-high reset.
REQ-007 SHALL have ports: in_psel, in_penable, in_pwrite in 1; in_paddr, in_pwdata in 32; in_prdata out 32; in_pready, in_pslverr out 1.
REQ-008 SHALL have ports: out_psel out NUM_SLAVES; out_penable, out_pwrite out 1; out_paddr, out_pwdata out 32, all shared.
REQ-009 SHALL have ports: out_prdata in NUM_SLAVES*32, slave i at bits [32i+31:32i]; out_pready, out_pslverr in NUM_SLAVES.
REQ-010 SHALL have ports: stat_timeout out 1 and stat_decerr out 1, one-cycle event pulses.

Function
REQ-011 Decode: idx = paddr[SEL_LSB+SEL_W-1:SEL_LSB] - SEL_BASE, unsigned; mapped iff field >= SEL_BASE and idx < NUM_SLAVES.
REQ-012 FSM states: IDLE, SETUP, ACCESS, RESP; all outputs registered.
REQ-013 IDLE: in_psel=1 and in_penable=0 SHALL capture paddr, pwrite, pwdata and idx; mapped -> SETUP, unmapped -> RESP with error.
REQ-014 SETUP: out_psel[idx]=1, out_penable=0, captured addr/write/data driven for one cycle -> ACCESS.
REQ-015 ACCESS: out_psel[idx]=1, out_penable=1; out_pready[idx]=1 -> capture out_prdata[idx] and out_pslverr[idx] -> RESP.
REQ-016 RESP: in_pready=1 for exactly one cycle with captured in_prdata and in_pslverr -> IDLE; in_pready SHALL be 0 in all other states.
REQ-017 Latency: a zero-wait slave SHALL give in_pready in the 3rd cycle after the setup cycle; each slave wait state adds one cycle.
REQ-018 Timeout: a counter SHALL clear on entering ACCESS and increment each ACCESS cycle without pready; at TIMEOUT_CYCLES-1 it SHALL drop out_psel/out_penable -> RESP with in_pslverr=1, in_prdata=0, and pulse stat_timeout.
REQ-019 Unmapped access SHALL give RESP with in_pslverr=1, in_prdata=0, pulse stat_decerr, and assert no out_psel bit.
REQ-020 Simultaneous pready and timeout limit in the same cycle: pready SHALL win, with no error and no stat_timeout.
REQ-021 At most one out_psel bit SHALL be set in any cycle; out_penable=1 only in ACCESS.
REQ-022 out_paddr/out_pwrite/out_pwdata SHALL hold their captured values from SETUP through ACCESS.
REQ-023 in_psel deasserted mid-transfer (protocol violation) SHALL NOT abort the downstream transfer; the response is still issued in RESP.
REQ-024 A new transfer SHALL be accepted only in IDLE; back-to-back transfers incur one IDLE cycle.

Reset
REQ-025 preset=1 SHALL on the next pclk edge force IDLE and clear the counter; all outputs go to 0, including in_prdata, out_paddr and out_pwdata.
REQ-026 Reset mid-operation SHALL abandon the transfer with no in_pready and no stat pulse.

Structure
REQ-027 Package apb_splitter_pkg SHALL hold the FSM state enum, the data/address width constants (32) and the decode-result typedef.
REQ-028 Address decode SHALL be a sub-module, apb_splitter_decode (combinational: paddr -> idx, mapped).

Verification
REQ-029 Default params: write 0x4000_0010, slave 0 zero-wait -> out_psel=01; in_pready in the 3rd cycle; in_pslverr=0.
REQ-030 Read 0x5000_0004, slave 1 with 3 wait states returning 0xDEAD_BEEF -> in_prdata=0xDEAD_BEEF; in_pready in the 6th cycle.
REQ-031 Access 0x7000_0000 -> out_psel=00 throughout; in_pslverr=1, in_prdata=0, stat_decerr pulses once.
REQ-032 TIMEOUT_CYCLES=8, slave never ready -> after 8 ACCESS cycles out_psel drops; in_pslverr=1; stat_timeout pulses.
REQ-033 TIMEOUT_CYCLES=8, pready on the limit cycle -> normal response; no stat_timeout.
REQ-034 preset asserted during ACCESS -> next cycle all outputs 0 and FSM in IDLE; the following transfer completes normally.
